// File: rtl/cpu_io_responder_pkg.sv
// Shared types for the CPU I/O responder: FSM state encoding and a width helper.
package cpu_io_responder_pkg;

    typedef enum logic [1:0] {
        rsp_idle       = 2'd0,
        rsp_read_wait  = 2'd1,
        rsp_write_wait = 2'd2
    } rsp_state_t;

    // Bit width able to index n items; never less than one bit.
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_io_responder_mem.sv
// DEPTH x DATA_W storage for the responder: synchronous write, asynchronous read.
module cpu_io_responder_mem
    import cpu_io_responder_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = width_for(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[idx] <= wdata;
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/cpu_io_responder.sv
// Word-addressed memory target for the CPU read/write handshake with fixed access latency.
// Optional IO_ADDR_CHECK_EN adds an err pulse and blocks accesses at or above DEPTH.
//
// state          | meaning
// rsp_idle       | waiting for control_write / control_read (write wins)
// rsp_read_wait  | read accepted, counting down, then rdata <= mem and ready pulse
// rsp_write_wait | write accepted, counting down, then mem write and ready pulse
module cpu_io_responder
    import cpu_io_responder_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              control_read,
    input  logic              control_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy
`ifdef IO_ADDR_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int IDX_W = width_for(DEPTH);
    localparam int CNT_W = width_for(WAIT_CYCLES + 1);

    rsp_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic              addr_oob;
    logic              done;

`ifdef IO_ADDR_CHECK_EN
    assign addr_oob = (32'(addr_q) >= 32'(DEPTH));
`else
    assign addr_oob = 1'b0;
`endif

    assign mem_idx = IDX_W'(32'(addr_q) % 32'(DEPTH));
    assign done    = ((state == rsp_read_wait) || (state == rsp_write_wait)) && (cnt == '0);
    // Gated by reset so a reset landing on the completion edge aborts the write.
    assign mem_we  = done && (state == rsp_write_wait) && reset && !addr_oob;

    cpu_io_responder_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .idx    (mem_idx),
        .wdata  (wdata_q),
        .rdata  (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= rsp_idle;
            cnt     <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            rdata   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef IO_ADDR_CHECK_EN
            err     <= 1'b0;
`endif
        end else begin
            ready <= 1'b0;
`ifdef IO_ADDR_CHECK_EN
            err   <= 1'b0;
`endif
            case (state)
                rsp_idle: begin
                    if (control_write || control_read) begin
                        state   <= control_write ? rsp_write_wait : rsp_read_wait;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= CNT_W'(WAIT_CYCLES);
                        busy    <= 1'b1;
                    end
                end
                rsp_read_wait, rsp_write_wait: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        state <= rsp_idle;
                        if (state == rsp_read_wait)
                            rdata <= addr_oob ? '0 : mem_rdata;
`ifdef IO_ADDR_CHECK_EN
                        err   <= addr_oob;
`endif
                    end
                end
                default: state <= rsp_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_io_responder.sv
// Directed bench for cpu_io_responder: one instance with WAIT_CYCLES=2/DEPTH=64, one with WAIT_CYCLES=0.
module tb_cpu_io_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        a_rd, a_wr, a_ready, a_busy;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic        b_rd, b_wr, b_ready, b_busy;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
`ifdef IO_ADDR_CHECK_EN
    logic        a_err, b_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cpu_io_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(64), .WAIT_CYCLES(2)) dut_a (
        .clk           (clk),
        .reset         (reset),
        .control_read  (a_rd),
        .control_write (a_wr),
        .addr          (a_addr),
        .wdata         (a_wdata),
        .rdata         (a_rdata),
        .ready         (a_ready),
        .busy          (a_busy)
`ifdef IO_ADDR_CHECK_EN
        ,
        .err           (a_err)
`endif
    );

    cpu_io_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .control_read  (b_rd),
        .control_write (b_wr),
        .addr          (b_addr),
        .wdata         (b_wdata),
        .rdata         (b_rdata),
        .ready         (b_ready),
        .busy          (b_busy)
`ifdef IO_ADDR_CHECK_EN
        ,
        .err           (b_err)
`endif
    );

    // Drives one request on dut_a, holds it until ready (bounded), then drops it.
    // lat counts negedges after the request was driven; -1 on timeout.
    task automatic a_xact(input logic wr, input logic rd, input logic [7:0] ad,
                          input logic [31:0] wd, output int lat,
                          output logic [7:0] busy_hist, output logic err_seen);
        busy_hist = '0;
        lat       = -1;
        err_seen  = 1'b0;
        @(negedge clk);
        a_wr = wr; a_rd = rd; a_addr = ad; a_wdata = wd;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k < 8) busy_hist[k] = a_busy;
            if (a_ready) begin
                lat = k;
`ifdef IO_ADDR_CHECK_EN
                err_seen = a_err;
`endif
                break;
            end
        end
        a_wr = 1'b0; a_rd = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (a_ready !== 1'b0) begin $display("FAIL reset_ready: got %b expected 0", a_ready); n_fail++; end
        n_checks++;
        if (a_busy !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", a_busy); n_fail++; end
        n_checks++;
        if (a_rdata !== 32'h0) begin $display("FAIL reset_rdata: got %h expected 0", a_rdata); n_fail++; end
        n_checks++;
        if ({b_ready, b_busy} !== 2'b00) begin $display("FAIL reset_b_flags: got %b expected 00", {b_ready, b_busy}); n_fail++; end
        reset = 1'b1;
    endtask

    task automatic test_write_latency;
        int lat; logic [7:0] bh; logic e;
        a_xact(1'b1, 1'b0, 8'h10, 32'hDEADBEEF, lat, bh, e);
        n_checks++;
        if (lat !== 4) begin $display("FAIL write_latency: got %0d expected 4", lat); n_fail++; end
        n_checks++;
        if (bh[4:1] !== 4'b0111) begin $display("FAIL write_busy: got %b expected 0111", bh[4:1]); n_fail++; end
        @(negedge clk);
        n_checks++;
        if (a_ready !== 1'b0) begin $display("FAIL write_ready_single: got %b expected 0", a_ready); n_fail++; end
    endtask

    task automatic test_read_hold;
        int lat; logic [7:0] bh; logic e;
        a_xact(1'b0, 1'b1, 8'h10, 32'h0, lat, bh, e);
        n_checks++;
        if (lat !== 4) begin $display("FAIL read_latency: got %0d expected 4", lat); n_fail++; end
        n_checks++;
        if (a_rdata !== 32'hDEADBEEF) begin $display("FAIL read_data: got %h expected deadbeef", a_rdata); n_fail++; end
        a_xact(1'b1, 1'b0, 8'h20, 32'h12345678, lat, bh, e);
        n_checks++;
        if (a_rdata !== 32'hDEADBEEF) begin $display("FAIL read_hold: got %h expected deadbeef", a_rdata); n_fail++; end
    endtask

    task automatic test_write_priority;
        int lat; logic [7:0] bh; logic e;
        a_xact(1'b1, 1'b1, 8'h05, 32'h1, lat, bh, e);
        n_checks++;
        if (a_rdata !== 32'hDEADBEEF) begin $display("FAIL prio_no_read: got %h expected deadbeef", a_rdata); n_fail++; end
        a_xact(1'b0, 1'b1, 8'h05, 32'h0, lat, bh, e);
        n_checks++;
        if (a_rdata !== 32'h1) begin $display("FAIL prio_written: got %h expected 1", a_rdata); n_fail++; end
        a_xact(1'b0, 1'b1, 8'h20, 32'h0, lat, bh, e);
        n_checks++;
        if (a_rdata !== 32'h12345678) begin $display("FAIL prio_other_word: got %h expected 12345678", a_rdata); n_fail++; end
    endtask

    task automatic test_back_to_back;
        int wr_idx; int readies; logic exp_rdy; bit got;
        @(negedge clk);
        b_wr = 1'b1; b_addr = 8'd1; b_wdata = 32'd1;
        wr_idx = 1; readies = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_rdy = (k % 2 == 0);
            n_checks++;
            if (b_ready !== exp_rdy) begin $display("FAIL b2b_ready_%0d: got %b expected %b", k, b_ready, exp_rdy); n_fail++; end
            if (b_ready) begin
                readies++;
                wr_idx++;
                if (wr_idx > 4) b_wr = 1'b0;
                else begin b_addr = 8'(wr_idx); b_wdata = 32'(wr_idx); end
            end
        end
        n_checks++;
        if (readies !== 4) begin $display("FAIL b2b_count: got %0d expected 4", readies); n_fail++; end
        @(negedge clk);
        n_checks++;
        if (b_ready !== 1'b0) begin $display("FAIL b2b_stray: got %b expected 0", b_ready); n_fail++; end
        for (int i = 1; i <= 4; i++) begin
            b_rd = 1'b1; b_addr = 8'(i);
            got = 1'b0;
            for (int k = 0; k < 4 && !got; k++) begin
                @(negedge clk);
                if (b_ready) got = 1'b1;
            end
            b_rd = 1'b0;
            n_checks++;
            if (!got || b_rdata !== 32'(i)) begin
                $display("FAIL b2b_readback_%0d: got %h (ready %b) expected %h", i, b_rdata, got, 32'(i));
                n_fail++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort;
        int lat; logic [7:0] bh; logic e; bit seen;
        a_xact(1'b1, 1'b0, 8'h30, 32'h11111111, lat, bh, e);
        a_xact(1'b0, 1'b1, 8'h30, 32'h0, lat, bh, e);
        n_checks++;
        if (a_rdata !== 32'h11111111) begin $display("FAIL abort_setup: got %h expected 11111111", a_rdata); n_fail++; end
        @(negedge clk);
        a_wr = 1'b1; a_addr = 8'h30; a_wdata = 32'h22222222;
        @(negedge clk);
        n_checks++;
        if (a_busy !== 1'b1) begin $display("FAIL abort_accepted: got %b expected 1", a_busy); n_fail++; end
        reset = 1'b0; a_wr = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_busy, a_ready} !== 2'b00) begin $display("FAIL abort_flags: got %b expected 00", {a_busy, a_ready}); n_fail++; end
        n_checks++;
        if (a_rdata !== 32'h0) begin $display("FAIL abort_rdata: got %h expected 0", a_rdata); n_fail++; end
        reset = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (a_ready) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin $display("FAIL abort_no_ready: got %b expected 0", seen); n_fail++; end
        a_xact(1'b0, 1'b1, 8'h30, 32'h0, lat, bh, e);
        n_checks++;
        if (a_rdata !== 32'h11111111) begin $display("FAIL abort_word_kept: got %h expected 11111111", a_rdata); n_fail++; end
    endtask

    task automatic test_addr_range;
        int lat; logic [7:0] bh; logic e;
        a_xact(1'b1, 1'b0, 8'h03, 32'h55, lat, bh, e);
        a_xact(1'b1, 1'b0, 8'd67, 32'hAA, lat, bh, e);
        n_checks++;
        if (lat !== 4) begin $display("FAIL range_ready: got %0d expected 4", lat); n_fail++; end
`ifdef IO_ADDR_CHECK_EN
        n_checks++;
        if (e !== 1'b1) begin $display("FAIL range_err: got %b expected 1", e); n_fail++; end
        a_xact(1'b0, 1'b1, 8'h03, 32'h0, lat, bh, e);
        n_checks++;
        if (a_rdata !== 32'h55) begin $display("FAIL range_mem_kept: got %h expected 55", a_rdata); n_fail++; end
        n_checks++;
        if (e !== 1'b0) begin $display("FAIL range_err_clear: got %b expected 0", e); n_fail++; end
        a_xact(1'b0, 1'b1, 8'd67, 32'h0, lat, bh, e);
        n_checks++;
        if (a_rdata !== 32'h0 || e !== 1'b1) begin $display("FAIL range_read: got %h err %b expected 0 err 1", a_rdata, e); n_fail++; end
`else
        a_xact(1'b0, 1'b1, 8'h03, 32'h0, lat, bh, e);
        n_checks++;
        if (a_rdata !== 32'hAA) begin $display("FAIL range_wrap: got %h expected aa", a_rdata); n_fail++; end
        a_xact(1'b0, 1'b1, 8'd67, 32'h0, lat, bh, e);
        n_checks++;
        if (a_rdata !== 32'hAA) begin $display("FAIL range_wrap_read: got %h expected aa", a_rdata); n_fail++; end
`endif
    endtask

    initial begin
        reset = 1'b0;
        a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
        b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
        test_reset();
        test_write_latency();
        test_read_hold();
        test_write_priority();
        test_back_to_back();
        test_reset_abort();
        test_addr_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
